// File: rtl/branch_predict_ctrl.sv
// Branch predictor and PC-select control: 2-bit saturating counter table read in IF,
// resolved in ID with redirect/flush generation and branch statistics.
module branch_predict_ctrl #(
  parameter int         IDX_W      = 4,
  parameter int         PC_W       = 32,
  parameter int         CNT_W      = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       if_opcode,
  input  logic [PC_W-1:0]  if_pc,
  input  logic [5:0]       id_opcode,
  input  logic             is_jr,
  input  logic             zero_flag,
  input  logic             stall,
  input  logic             stat_clr,
  output logic [2:0]       pc_src,
  output logic             IF_flush,
  output logic             pred_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int         ENTRIES = 1 << IDX_W;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]       ctr_tbl [ENTRIES];
  logic [IDX_W-1:0] idx_p0;
  logic             is_br_p0;
  logic             unused_pc;

  logic             vld_p1;
  logic             pred_p1;
  logic [IDX_W-1:0] idx_p1;
  logic             is_beq_p1, is_bne_p1;
  logic             resolved_p1, actual_p1, upd_p1;

  // IF stage: table lookup
  assign idx_p0     = if_pc[IDX_W+1:2];
  assign unused_pc  = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};
  assign is_br_p0   = (if_opcode == OP_BEQ) || (if_opcode == OP_BNE);
  assign pred_taken = is_br_p0 & ctr_tbl[idx_p0][1];

  // ID stage: resolution against the prediction carried in the shadow
  assign is_beq_p1   = (id_opcode == OP_BEQ);
  assign is_bne_p1   = (id_opcode == OP_BNE);
  assign resolved_p1 = vld_p1 & (is_beq_p1 | is_bne_p1);
  assign actual_p1   = (is_beq_p1 & zero_flag) | (is_bne_p1 & ~zero_flag);
  assign upd_p1      = resolved_p1 & ~stall & ~is_jr;

  always_comb begin
    pc_src = 3'b000;
    if (is_jr)                                       pc_src = 3'b011;
    else if (id_opcode == OP_J || id_opcode == OP_JAL) pc_src = 3'b010;
    else if (resolved_p1 && actual_p1 && !pred_p1)   pc_src = 3'b100;
    else if (resolved_p1 && !actual_p1 && pred_p1)   pc_src = 3'b101;
    else if (pred_taken)                             pc_src = 3'b001;
  end

  assign IF_flush = (pc_src == 3'b010) || (pc_src == 3'b011) ||
                    (pc_src == 3'b100) || (pc_src == 3'b101);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pred_p1 <= 1'b0;
      idx_p1  <= '0;
    end else if (!stall) begin
      if (IF_flush) begin
        vld_p1 <= 1'b0;
      end else begin
        vld_p1  <= 1'b1;
        pred_p1 <= pred_taken;
        idx_p1  <= idx_p0;
      end
    end
  end

  // Update stage: counter table written with the resolved outcome; reads see the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_tbl[i] <= INIT_STATE;
    end else if (upd_p1) begin
      ctr_tbl[idx_p1] <= sat_ctr(ctr_tbl[idx_p1], actual_p1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (stat_clr) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (upd_p1) begin
      br_count <= sat_inc(br_count);
      if (pred_p1 != actual_p1) mispred_count <= sat_inc(mispred_count);
    end
  end

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 Parameter IDX_W, default 4, predictor index width; the table has 2^IDX_W entries.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 Parameter CNT_W, default 16, statistics counter width.
REQ-004 Parameter INIT_STATE, default 2'b01, reset value of every 2-bit counter (weakly not-taken).
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 if_opcode  in  6  opcode of the instruction in IF.
REQ-008 if_pc  in  PC_W  PC of the instruction in IF.
REQ-009 id_opcode  in  6  opcode of the instruction in ID.
REQ-010 is_jr  in  1  the ID instruction is jr.
REQ-011 zero_flag  in  1  ID-stage register-compare result (1 = operands equal).
REQ-012 stall  in  1  IF/ID hold from the hazard unit; 1 = IF/ID register frozen.
REQ-013 stat_clr  in  1  synchronous clear of the statistics counters.
REQ-014 pc_src  out  3  PC select: 000 pc+4, 001 IF predicted target, 010 j/jal target, 011 jr target, 100 ID branch target, 101 ID branch pc+4.
REQ-015 IF_flush  out  1  squash the IF/ID register.
REQ-016 pred_taken  out  1  IF prediction for the current if_pc.
REQ-017 br_count  out  CNT_W  resolved conditional branches.
REQ-018 mispred_count  out  CNT_W  mispredicted conditional branches.

Function
REQ-019 The table SHALL hold 2^IDX_W 2-bit saturating counters indexed by pc[IDX_W+1:2].
REQ-020 pred_taken SHALL equal 1 only when if_opcode is beq (000100) or bne (000101) and counter[idx(if_pc)][1]=1; it is combinational.
REQ-021 An internal IF/ID shadow (valid, pred, idx) SHALL load {1, pred_taken, idx(if_pc)} on each edge with stall=0 and IF_flush=0.
REQ-022 On an edge with IF_flush=1 and stall=0, the shadow valid SHALL clear to 0; with stall=1 the shadow SHALL hold.
REQ-023 The ID branch is resolved when shadow valid=1 and id_opcode is beq/bne; actual taken = (beq and zero_flag) or (bne and not zero_flag).
REQ-024 pc_src priority (combinational): is_jr -> 011; id_opcode j/jal (000010/000011) -> 010; resolved, actual=1, pred=0 -> 100; resolved, actual=0, pred=1 -> 101; pred_taken=1 -> 001; else 000.
REQ-025 IF_flush SHALL be 1 exactly when pc_src is 010, 011, 100 or 101; a correct prediction SHALL NOT flush.
REQ-026 A predicted-taken IF branch SHALL be overridden (pc_src not 001) whenever an ID redirect is active in the same cycle.
REQ-027 Counter update SHALL occur once per branch, on the edge with a resolved branch and stall=0: increment saturating at 11 if taken, else decrement saturating at 00.
REQ-028 A same-cycle read and update of one entry SHALL return the pre-update value (no bypass).
REQ-029 br_count SHALL increment on every update edge; mispred_count SHALL increment when the prediction differed from the actual outcome; both saturate at all ones.
REQ-030 stat_clr SHALL zero both statistics counters and take priority over a same-edge increment.
REQ-031 jr, j and jal SHALL NOT update the table or the statistics.

Reset
REQ-032 With rst_n=0, every table entry SHALL be INIT_STATE, shadow valid, pred and idx SHALL be 0, and br_count and mispred_count SHALL be 0, asynchronously.
REQ-033 During and immediately after reset (INIT_STATE[1]=0, no jump in ID), pc_src SHALL be 000 and IF_flush SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard any pending update and any in-flight prediction.

Verification
REQ-035 Reset; beq at if_pc 0x40 -> pred_taken=0, pc_src=000; next cycle in ID with zero_flag=1 -> pc_src=100, IF_flush=1, entry 0 becomes 10, mispred_count=1.
REQ-036 Repeat the same beq, taken -> pred_taken=1, pc_src=001; in ID no flush, entry 0 becomes 11; third taken pass stays 11.
REQ-037 With entry 0 at 11, bne at 0x40 and zero_flag=1 -> pc_src=101, IF_flush=1, entry 0 becomes 10, mispred_count +1.
REQ-038 jr in ID while the IF branch is predicted taken -> pc_src=011, IF_flush=1, no table or counter change.
REQ-039 Resolving branch held in ID with stall=1 for 3 cycles then released -> exactly one update, br_count +1.
REQ-040 rst_n pulled low mid-stream with entries at 11 -> all entries 01, counters 0, pc_src=000 immediately; stat_clr coinciding with a mispredict -> both counters 0.
